// File: rtl/comparator_seq_if.sv
// Request/response bundle for the iterative magnitude comparator.
// The slave modport is the comparator side; master is the requester/consumer side.
interface comparator_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
);
  localparam int unsigned CNT_W = $clog2(WIDTH / CHUNK + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_gt;
  logic             out_lt;
  logic             out_eq;
  logic [CNT_W-1:0] out_chunks;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_gt, out_lt, out_eq, out_chunks
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_gt, out_lt, out_eq, out_chunks
  );
endinterface

// File: rtl/comparator_seq.sv
// Iterative gt/lt/eq comparator: scans CHUNK bits per cycle from the MSB and
// stops at the first unequal chunk. Signed mode biases the sign bit, then compares unsigned.
module comparator_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              reset,
  comparator_seq_if.slave  bus
);
  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("comparator_seq: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("comparator_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] chunks_q, chunks_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [CHUNK-1:0] a_top, b_top;

  // Operands shift left each cycle so the chunk under test is always on top.
  assign a_top = a_q[WIDTH-1 -: CHUNK];
  assign b_top = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    chunks_d    = chunks_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a ^ (bus.in_signed ? SIGN_MASK : '0);
          b_d        = bus.in_b ^ (bus.in_signed ? SIGN_MASK : '0);
          idx_d      = IDX_W'(N - 1);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CMP;
        end
      end
      CMP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (a_top != b_top) begin
          gt_d        = (a_top > b_top);
          lt_d        = (a_top < b_top);
          eq_d        = 1'b0;
          chunks_d    = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          gt_d        = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b1;
          chunks_d    = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      chunks_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      chunks_q    <= chunks_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_gt     = gt_q;
  assign bus.out_lt     = lt_q;
  assign bus.out_eq     = eq_q;
  assign bus.out_chunks = chunks_q;
endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq (WIDTH=32, CHUNK=4): directed vectors plus random
// requests, checked every cycle against an arithmetic reference model.
module tb_comparator_seq;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct {
    bit gt;
    bit lt;
    bit eq;
    int m;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  comparator_seq_if #(.WIDTH(W), .CHUNK(C)) bus ();

  comparator_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned compare; m = length of the shortest
  // differing MSB prefix, in chunks (N when the operands are equal).
  function automatic res_t ref_cmp(input logic [31:0] a, input logic [31:0] b, input bit s);
    res_t r;
    if (s) begin
      r.gt = ($signed(a) > $signed(b));
      r.lt = ($signed(a) < $signed(b));
    end else begin
      r.gt = (a > b);
      r.lt = (a < b);
    end
    r.eq = (a == b);
    r.m  = N;
    for (int k = 0; k < N; k++) begin
      if ((a >> (W - (k + 1) * C)) != (b >> (W - (k + 1) * C))) begin
        r.m = k + 1;
        break;
      end
    end
    return r;
  endfunction

  // Cycle model: outstanding request counts down m edges, then is presented until taken.
  bit   m_pend = 1'b0;
  bit   m_pres = 1'b0;
  int   m_left = 0;
  res_t m_res  = '{gt: 1'b0, lt: 1'b0, eq: 1'b0, m: 0};
  res_t m_next;

  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      check("in_ready",   32'(bus.in_ready),   32'(!(m_pend || m_pres)));
      check("out_valid",  32'(bus.out_valid),  32'(m_pres));
      check("out_gt",     32'(bus.out_gt),     32'(m_res.gt));
      check("out_lt",     32'(bus.out_lt),     32'(m_res.lt));
      check("out_eq",     32'(bus.out_eq),     32'(m_res.eq));
      check("out_chunks", 32'(bus.out_chunks), 32'(m_res.m));
      if (bus.out_valid)
        check("onehot", 32'(bus.out_gt) + 32'(bus.out_lt) + 32'(bus.out_eq), 32'd1);
      if (reset) begin
        m_pend = 1'b0;
        m_pres = 1'b0;
        m_left = 0;
        m_res  = '{gt: 1'b0, lt: 1'b0, eq: 1'b0, m: 0};
      end else if (m_pres) begin
        if (bus.out_ready) m_pres = 1'b0;
      end else if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 1'b0;
          m_pres = 1'b1;
          m_res  = m_next;
        end
      end else if (bus.in_valid) begin
        m_next = ref_cmp(bus.in_a, bus.in_b, bus.in_signed);
        m_pend = 1'b1;
        m_left = m_next.m;
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int hold, input bit junk);
    res_t r;
    int   cyc;
    bit   seen;
    r = ref_cmp(a, b, s);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (junk) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        bus.in_signed = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
      seen = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(r.m));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    res_t r;
    logic [31:0] a, b, mask;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Hand-computed expectations that pin the reference model.
    r = ref_cmp(32'h80000000, 32'h00000001, 1'b0);
    check("model_u_gt", 32'(r.gt), 32'd1);
    check("model_u_m",  32'(r.m),  32'd1);
    r = ref_cmp(32'h80000000, 32'h00000001, 1'b1);
    check("model_s_lt", 32'(r.lt), 32'd1);
    r = ref_cmp(32'h12345678, 32'h12345678, 1'b0);
    check("model_eq",   32'(r.eq), 32'd1);
    check("model_eq_m", 32'(r.m),  32'd8);
    r = ref_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    check("model_neg_gt", 32'(r.gt), 32'd1);
    check("model_neg_m",  32'(r.m),  32'd8);

    // Directed vectors with literal result checks (results persist in IDLE).
    run_req(32'h80000000, 32'h00000001, 1'b0, 0, 1'b0);
    check("d1_gt", 32'(bus.out_gt), 32'd1);
    check("d1_chunks", 32'(bus.out_chunks), 32'd1);
    run_req(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0);
    check("d2_lt", 32'(bus.out_lt), 32'd1);
    check("d2_chunks", 32'(bus.out_chunks), 32'd1);
    run_req(32'h12345678, 32'h12345678, 1'b0, 1, 1'b0);
    check("d3_eq", 32'(bus.out_eq), 32'd1);
    check("d3_chunks", 32'(bus.out_chunks), 32'd8);
    run_req(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0, 1'b0);
    check("d4_gt", 32'(bus.out_gt), 32'd1);
    check("d4_chunks", 32'(bus.out_chunks), 32'd8);
    run_req(32'h00000000, 32'h00000001, 1'b0, 5, 1'b0);
    check("d5_lt", 32'(bus.out_lt), 32'd1);

    // Reset sampled at T+3 while comparing a long (m=8) request.
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h12345678;
    bus.in_b     = 32'h12345678;
    bus.in_signed = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),   32'd1);
    check("rst_out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_gt",        32'(bus.out_gt),     32'd0);
    check("rst_lt",        32'(bus.out_lt),     32'd0);
    check("rst_eq",        32'(bus.out_eq),     32'd0);
    check("rst_chunks",    32'(bus.out_chunks), 32'd0);
    run_req(32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1'b0);
    check("d6_gt", 32'(bus.out_gt), 32'd1);

    // Random requests, biased toward shared leading chunks.
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'h1 << $urandom_range(0, 31));
        default: begin
          mask = (32'h1 << $urandom_range(0, 31)) - 32'h1;
          b = (a & ~mask) | ($urandom & mask);
        end
      endcase
      run_req(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
